sys_array_sequencer: RTL
========================

# sys_array_sequencer

Command-level controller for the systolic matrix-multiply array. It accepts one `ctrl_t` command at a time and reads the A and B operand rows from memory. It paces the array input stage through the skew flush, then drains the result rows to C memory. It sits between the host command interface and the array/memory ports and owns all array sequencing.

## Interface
Parameters:
- `N`, `SYS_ARRAY_SIZE` (2): array dimension; rows per operand, skew from `T_D`.
- `AW`, `ADDR_WIDTH` (64): address width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer idle; command accepted on `cmd_valid && cmd_ready`.
- `cmd`  in  `ctrl_t`  compute_req, drain_en, a/b/c base addresses.
- `rd_valid`  out  1  row read request.
- `rd_ready`  in  1  memory accepts read; row data valid next cycle.
- `rd_addr`  out  AW  row address.
- `rd_sel`  out  1  0 = A row, 1 = B row.
- `feed_en`  out  1  array input stage captures A/B row this cycle.
- `feed_idx`  out  `mcount_t`  row index k being fed.
- `feed_last`  out  1  k == N-1 (drives `matrix_data_t.last`).
- `drain_en`  out  1  PE drain path enabled (`drain_data_t.enable`).
- `wr_valid`  out  1  C row write request.
- `wr_ready`  in  1  memory accepts write.
- `wr_addr`  out  AW  C row address.
- `drain_shift`  out  1  advance drain chain by one row (on write handshake).
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: `cmd_ready=1`. On accept, latch `cmd`, then:
  - compute_req=1: go to LOAD.
  - compute_req=0, drain_en=1: go to DRAIN.
  - both 0: go to DONE.
- `cmd_valid` outside IDLE is ignored. The latched command is immutable until DONE.
- LOAD: for k = 0..N-1, issue A row k at `a_addr + k*N`, then B row k at `b_addr + k*N`.
  - Row stride is N bytes (`ROW_STRIDE`).
  - `rd_valid`, `rd_addr` and `rd_sel` stay stable until `rd_ready`. `rd_valid` never drops before handshake.
  - `feed_en` pulses for 1 cycle, the cycle after each B-row handshake, with `feed_idx=k` and `feed_last=(k==N-1)`.
  - The handshake on B row N-1 moves the FSM to COMPUTE.
- COMPUTE: count exactly T_D cycles (skew flush). Then go to DRAIN if drain_en, else DONE.
- DRAIN: `drain_en=1` for the whole state. For r = 0..N-1, issue a write at `c_addr + r*N`.
  - `wr_valid` and `wr_addr` stay stable until `wr_ready`.
  - `drain_shift` pulses on each handshake.
  - The handshake on row N-1 moves the FSM to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Address arithmetic is unsigned modulo 2^AW; wrap-around is silent.
- Row/beat counters are `mcount_t`. The skew counter is `$clog2(T_D+1)` bits.

## Timing
- Reset values: state IDLE, `cmd_ready=1` (after the reset edge), all other outputs 0, counters 0.
- While `rst=1`, the FSM is held in IDLE regardless of other inputs.
- Reset mid-operation abandons the command: no `done`, no further requests, and outstanding handshakes are dropped.
- Cycle 0 is the accept cycle. With `rd_ready`/`wr_ready` tied high:
  - LOAD occupies cycles 1..2N.
  - `feed_en` is asserted at cycles 3, 5, .., 2N+1.
  - COMPUTE occupies cycles 2N+1..2N+T_D.
  - DRAIN occupies cycles 2N+T_D+1..3N+T_D.
  - `done` fires at cycle 3N+T_D+1. For N=2 that is cycle 11; without drain it is cycle 2N+T_D+1 = 9.
- Each stalled cycle on `rd_ready`/`wr_ready` adds exactly one cycle of latency.
- `feed_en` may coincide with the next A-row request. The last feed coincides with the first COMPUTE cycle.
- The earliest next command is accepted the cycle after `done`.

## Structure
- Add to `common_pkg`:
  - `seq_state_t` enum (IDLE, LOAD, COMPUTE, DRAIN, DONE).
  - `ROW_STRIDE` = N*DATA_WIDTH/8.
  - `SKEW_CNT_WIDTH`.
- Reuse `ctrl_t`, `mcount_t` and `addr_t` from the package.
- One sub-module, `row_addr_gen`: computes base + idx*ROW_STRIDE for a latched base. It is instantiated for reads (mux a/b by `rd_sel`) and for writes.

## Test plan
- Nominal: cmd {compute_req=1, drain_en=1, a=0x100, b=0x200, c=0x300}, readies high -> reads 0x100, 0x200, 0x102, 0x202; `feed_en` at cycles 3 and 5 with last at 5; writes 0x300, 0x302 at cycles 9 and 10; `done` at 11.
- Read backpressure: `rd_ready` low for 3 cycles on B row 0 -> `rd_addr` holds 0x200, `feed_en` delayed 3 cycles, `done` at 14.
- Drain-only {0,1} with `wr_ready` low 2 cycles on row 1 -> no reads, `drain_en` high throughout DRAIN, `done` at cycle 5.
- Compute without drain {1,0}, then a second command offered at `done` -> `done` at 9, no writes, second command accepted at cycle 10 only.
- Reset asserted at COMPUTE cycle 6 -> next cycle: IDLE, `cmd_ready=1`, all others 0, no `done` pulse.
- Wrap: a_addr=0xFFFF_FFFF_FFFF_FFFF -> A row 1 address = 0x0000_0000_0000_0001.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and constants for the systolic array control path.
package common_pkg;

   localparam int SYS_ARRAY_SIZE = 2;
   localparam int DATA_WIDTH     = 8;
   localparam int ADDR_WIDTH     = 64;
   localparam int T_D            = 2 * SYS_ARRAY_SIZE;
   localparam int ROW_STRIDE     = SYS_ARRAY_SIZE * DATA_WIDTH / 8;
   localparam int SKEW_CNT_WIDTH = $clog2(T_D + 1);
   localparam int MCOUNT_WIDTH   = $clog2(SYS_ARRAY_SIZE + 1);

   typedef logic [ADDR_WIDTH-1:0]     addr_t;
   typedef logic [MCOUNT_WIDTH-1:0]   mcount_t;
   typedef logic [SKEW_CNT_WIDTH-1:0] skew_cnt_t;

   typedef struct packed {
      logic  compute_req;
      logic  drain_en;
      addr_t a_addr;
      addr_t b_addr;
      addr_t c_addr;
   } ctrl_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } seq_state_t;

endpackage

// File: rtl/row_addr_gen.sv
// Row address generator: base + idx * stride, wrapping silently modulo 2^AW.
module row_addr_gen
   import common_pkg::*;
#(
   parameter int AW     = ADDR_WIDTH,
   parameter int STRIDE = ROW_STRIDE
) (
   input  logic [AW-1:0] base_i,
   input  mcount_t       idx_i,
   output logic [AW-1:0] addr_o
);

   assign addr_o = base_i + (AW'(idx_i) * AW'(STRIDE));

endmodule

// File: rtl/sys_array_sequencer.sv
// Command-level sequencer for the systolic array: operand row reads, skew
// flush pacing and result row drain, one command at a time.
module sys_array_sequencer
   import common_pkg::*;
#(
   parameter int N  = SYS_ARRAY_SIZE,
   parameter int AW = ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  ctrl_t         cmd,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [AW-1:0] rd_addr,
   output logic          rd_sel,
   output logic          feed_en,
   output mcount_t       feed_idx,
   output logic          feed_last,
   output logic          drain_en,
   output logic          wr_valid,
   input  logic          wr_ready,
   output logic [AW-1:0] wr_addr,
   output logic          drain_shift,
   output logic          busy,
   output logic          done
);

   localparam mcount_t   LAST_ROW  = mcount_t'(N - 1);
   localparam skew_cnt_t LAST_SKEW = skew_cnt_t'(T_D - 1);

   seq_state_t state_q, state_d;
   logic       drain_q, drain_d;
   addr_t      a_q, a_d, b_q, b_d, c_q, c_d;
   mcount_t    row_q, row_d;
   logic       sel_q, sel_d;
   skew_cnt_t  skew_q, skew_d;
   logic       feed_en_q, feed_en_d;
   mcount_t    feed_idx_q, feed_idx_d;
   logic       feed_last_q, feed_last_d;

   logic [AW-1:0] rd_base_s, rd_gen_s, wr_gen_s;

   // State and datapath registers; reset abandons any command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         drain_q     <= 1'b0;
         a_q         <= addr_t'(1'b0);
         b_q         <= addr_t'(1'b0);
         c_q         <= addr_t'(1'b0);
         row_q       <= mcount_t'(1'b0);
         sel_q       <= 1'b0;
         skew_q      <= skew_cnt_t'(1'b0);
         feed_en_q   <= 1'b0;
         feed_idx_q  <= mcount_t'(1'b0);
         feed_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         row_q       <= row_d;
         sel_q       <= sel_d;
         skew_q      <= skew_d;
         feed_en_q   <= feed_en_d;
         feed_idx_q  <= feed_idx_d;
         feed_last_q <= feed_last_d;
      end
   end

   // Next-state logic; each LOAD row is A then B, feed pulses after the B beat.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      row_d       = row_q;
      sel_d       = sel_q;
      skew_d      = skew_q;
      feed_en_d   = 1'b0;
      feed_idx_d  = mcount_t'(1'b0);
      feed_last_d = 1'b0;
      case (state_q)
         IDLE: begin
            row_d  = mcount_t'(1'b0);
            sel_d  = 1'b0;
            skew_d = skew_cnt_t'(1'b0);
            if (cmd_valid) begin
               drain_d = cmd.drain_en;
               a_d     = cmd.a_addr;
               b_d     = cmd.b_addr;
               c_d     = cmd.c_addr;
               if (cmd.compute_req) begin
                  state_d = LOAD;
               end else if (cmd.drain_en) begin
                  state_d = DRAIN;
               end else begin
                  state_d = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (rd_ready && sel_q) begin
               sel_d       = 1'b0;
               feed_en_d   = 1'b1;
               feed_idx_d  = row_q;
               feed_last_d = (row_q == LAST_ROW);
               if (row_q == LAST_ROW) begin
                  row_d   = mcount_t'(1'b0);
                  state_d = COMPUTE;
               end else begin
                  row_d = row_q + mcount_t'(1'b1);
               end
            end else if (rd_ready) begin
               sel_d = 1'b1;
            end else begin
               sel_d = sel_q;
            end
         end
         COMPUTE: begin
            if (skew_q == LAST_SKEW) begin
               skew_d  = skew_cnt_t'(1'b0);
               state_d = drain_q ? DRAIN : DONE;
            end else begin
               skew_d = skew_q + skew_cnt_t'(1'b1);
            end
         end
         DRAIN: begin
            if (wr_ready && (row_q == LAST_ROW)) begin
               row_d   = mcount_t'(1'b0);
               state_d = DONE;
            end else if (wr_ready) begin
               row_d = row_q + mcount_t'(1'b1);
            end else begin
               row_d = row_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rd_base_s = sel_q ? b_q : a_q;

   row_addr_gen #(.AW(AW), .STRIDE(ROW_STRIDE)) u_rd_addr (
      .base_i (rd_base_s),
      .idx_i  (row_q),
      .addr_o (rd_gen_s)
   );

   row_addr_gen #(.AW(AW), .STRIDE(ROW_STRIDE)) u_wr_addr (
      .base_i (c_q),
      .idx_i  (row_q),
      .addr_o (wr_gen_s)
   );

   // Addresses are forced to zero whenever no request is outstanding.
   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign rd_valid    = (state_q == LOAD);
   assign rd_sel      = sel_q;
   assign rd_addr     = rd_valid ? rd_gen_s : {AW{1'b0}};
   assign feed_en     = feed_en_q;
   assign feed_idx    = feed_idx_q;
   assign feed_last   = feed_last_q;
   assign drain_en    = (state_q == DRAIN);
   assign wr_valid    = (state_q == DRAIN);
   assign wr_addr     = wr_valid ? wr_gen_s : {AW{1'b0}};
   assign drain_shift = wr_valid && wr_ready;

endmodule
